// File: rtl/puzzle_pkg.sv
// Shared types and constants for the puzzle grid core: FSM states, LFSR constants, counter width.
package puzzle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCRAMBLE = 2'd1,
    ST_CHECK    = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_RESET   = 16'hACE1;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10), shifting toward the MSB.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam int unsigned MOVE_COUNT_W = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puzzle_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load; a zero seed falls back to LFSR_RESET.
module puzzle_lfsr16
  import puzzle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= LFSR_RESET;
    end else if (load) begin
      value <= (seed == 16'h0000) ? LFSR_RESET : seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/puzzle_grid_core.sv
// Row/column increment puzzle grid with optional LFSR scramble.
// Scramble logic is compiled in only when PUZZLE_GRID_SCRAMBLE_EN is defined.
module puzzle_grid_core
  import puzzle_pkg::*;
#(
  parameter int unsigned GRID_N         = 4,
  parameter int unsigned CELL_BITS      = 2,
  parameter int unsigned SCRAMBLE_MOVES = 16,
  localparam int unsigned IW            = $clog2(GRID_N)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              fire,
  input  logic                              sel_nrow,
  input  logic [IW-1:0]                     sel_idx,
  input  logic                              add_n,
  input  logic                              scramble_req,
  input  logic [15:0]                       seed,
  output logic [GRID_N*GRID_N*CELL_BITS-1:0] cell_state,
  output logic                              busy,
  output logic                              win,
  output logic                              sel_err,
  output logic [MOVE_COUNT_W-1:0]           move_count
);

  localparam int unsigned NCELL = GRID_N * GRID_N;

  logic [1:0]    rst_sync;
  logic          rst_n;
  state_t        state;
  logic          armed;
  logic          uniform;
  logic          scr_start;
  logic          user_ok;
  logic          mv_en;
  logic          mv_col;
  logic          mv_dec;
  logic [IW-1:0] mv_idx;
  logic [NCELL-1:0] eq;

  // Assert asynchronously, release on the second clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

`ifdef PUZZLE_GRID_SCRAMBLE_EN
  logic [15:0]   lfsr_value;
  logic [7:0]    scr_cnt;
  logic [IW-1:0] scr_raw;
  logic [IW-1:0] scr_idx;
  logic          scr_step;
  logic          unused_lfsr;

  assign scr_start   = (state == ST_IDLE) && scramble_req;
  assign scr_step    = (state == ST_SCRAMBLE);
  assign scr_raw     = lfsr_value[IW:1];
  assign scr_idx     = (32'(scr_raw) >= GRID_N) ? IW'(32'(scr_raw) - GRID_N) : scr_raw;
  assign unused_lfsr = ^lfsr_value[15:IW+1];

  puzzle_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (rst_n),
    .load  (scr_start),
    .seed  (seed),
    .step  (scr_step),
    .value (lfsr_value)
  );
`else
  logic unused_scr;
  assign scr_start  = 1'b0;
  assign unused_scr = ^{scramble_req, seed};
`endif

  assign user_ok = (32'(sel_idx) < GRID_N);

  // Select the move applied this cycle: a user move in IDLE or an LFSR move in SCRAMBLE.
  always_comb begin
    mv_en  = 1'b0;
    mv_col = sel_nrow;
    mv_idx = sel_idx;
    mv_dec = add_n;
    if (state == ST_IDLE && !scr_start && fire && user_ok) mv_en = 1'b1;
`ifdef PUZZLE_GRID_SCRAMBLE_EN
    if (state == ST_SCRAMBLE) begin
      mv_en  = 1'b1;
      mv_col = lfsr_value[0];
      mv_idx = scr_idx;
      mv_dec = 1'b0;
    end
`endif
  end

  for (genvar r = 0; r < GRID_N; r++) begin : g_row
    for (genvar c = 0; c < GRID_N; c++) begin : g_col
      localparam int unsigned K = r * GRID_N + c;
      logic [CELL_BITS-1:0] q;
      logic                 hit;

      assign hit = mv_col ? (32'(mv_idx) == 32'(c)) : (32'(mv_idx) == 32'(r));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             q <= '0;
        else if (mv_en && hit)  q <= mv_dec ? q - CELL_BITS'(1) : q + CELL_BITS'(1);
      end

      assign cell_state[K*CELL_BITS +: CELL_BITS] = q;
      assign eq[K] = (q == cell_state[CELL_BITS-1:0]);
    end
  end

  assign uniform = &eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      win        <= 1'b0;
      sel_err    <= 1'b0;
      armed      <= 1'b0;
      move_count <= '0;
`ifdef PUZZLE_GRID_SCRAMBLE_EN
      scr_cnt    <= 8'd0;
`endif
    end else begin
      sel_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scr_start) begin
            move_count <= '0;
            win        <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SCRAMBLE;
`ifdef PUZZLE_GRID_SCRAMBLE_EN
            scr_cnt    <= 8'd0;
`endif
          end else if (fire) begin
            if (user_ok) begin
              if (move_count != '1) move_count <= move_count + MOVE_COUNT_W'(1);
              armed <= 1'b1;
              state <= ST_CHECK;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
`ifdef PUZZLE_GRID_SCRAMBLE_EN
        ST_SCRAMBLE: begin
          scr_cnt <= scr_cnt + 8'd1;
          if (scr_cnt == 8'(SCRAMBLE_MOVES - 1)) begin
            busy  <= 1'b0;
            armed <= 1'b1;
            state <= ST_CHECK;
          end
        end
`endif
        ST_CHECK: begin
          win   <= uniform && armed;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle_grid_core.sv
// Self-checking bench for puzzle_grid_core: grid model plus directed vectors (GRID_N=4 and GRID_N=3).
module tb_puzzle_grid_core;

  localparam int N   = 4;
  localparam int CB  = 2;
  localparam int SM  = 16;
  localparam int MOD = 4;

  logic        clk = 1'b0;
  logic        reset, fire, sel_nrow, add_n, scramble_req;
  logic [1:0]  sel_idx;
  logic [15:0] seed;
  logic [31:0] cell_state;
  logic        busy, win, sel_err;
  logic [15:0] move_count;

  logic        fire3;
  logic [1:0]  idx3;
  logic [17:0] cell3;
  logic        busy3, win3, sel_err3;
  logic [15:0] count3;

  always #5 clk = ~clk;

  puzzle_grid_core #(.GRID_N(N), .CELL_BITS(CB), .SCRAMBLE_MOVES(SM)) dut (
    .clk(clk), .reset(reset), .fire(fire), .sel_nrow(sel_nrow), .sel_idx(sel_idx),
    .add_n(add_n), .scramble_req(scramble_req), .seed(seed), .cell_state(cell_state),
    .busy(busy), .win(win), .sel_err(sel_err), .move_count(move_count)
  );

  puzzle_grid_core #(.GRID_N(3), .CELL_BITS(CB), .SCRAMBLE_MOVES(SM)) dut3 (
    .clk(clk), .reset(reset), .fire(fire3), .sel_nrow(sel_nrow), .sel_idx(idx3),
    .add_n(add_n), .scramble_req(1'b0), .seed(seed), .cell_state(cell3),
    .busy(busy3), .win(win3), .sel_err(sel_err3), .move_count(count3)
  );

  // Model state
  int grid [N][N];
  int m_count;
  bit m_win, m_armed, m_busy, chk_pending, chk_en;
  int busy_cycles;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] f;
    f = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        f[(r*N+c)*CB +: CB] = CB'(grid[r][c]);
    return f;
  endfunction

  function automatic bit model_uniform();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (grid[r][c] != grid[0][0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_move(input bit col, input int idx, input bit dec);
    for (int i = 0; i < N; i++) begin
      if (col) grid[i][idx] = (grid[i][idx] + (dec ? MOD - 1 : 1)) % MOD;
      else     grid[idx][i] = (grid[idx][i] + (dec ? MOD - 1 : 1)) % MOD;
    end
  endtask

  function automatic int lfsr_model(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 'hFFFF;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) grid[r][c] = 0;
    m_count = 0; m_win = 0; m_armed = 0; m_busy = 0; chk_pending = 0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cells", 64'(cell_state), 64'(model_flat()));
      chk("move_count", 64'(move_count), 64'(m_count));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("win", 64'(win), 64'(m_win));
      chk("sel_err", 64'(sel_err), 64'(0));
      if (busy) busy_cycles++;
    end
  end

  task automatic hard_reset();
    chk_en = 0;
    reset  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (chk_pending) begin
      m_win = model_uniform() && m_armed;
      chk_pending = 0;
    end
    @(negedge clk);
  endtask

  task automatic move_fire(input bit col, input int idx, input bit dec);
    sel_nrow = col; sel_idx = 2'(idx); add_n = dec; fire = 1'b1;
    @(posedge clk);
    if (idx < N) begin
      model_move(col, idx, dec);
      if (m_count < 'hFFFF) m_count++;
      m_armed = 1; chk_pending = 1;
    end
    @(negedge clk);
    fire = 1'b0;
  endtask

  task automatic scramble(input logic [15:0] sv, input bit with_fire);
    int v;
    int idx;
    scramble_req = 1'b1; seed = sv; fire = with_fire;
    sel_nrow = 1'b0; sel_idx = 2'd0; add_n = 1'b1;
    @(posedge clk);
    m_count = 0; m_win = 0; m_busy = 1;
    v = (sv == 16'h0000) ? 'hACE1 : int'(sv);
    @(negedge clk);
    scramble_req = 1'b0; fire = 1'b0;
    for (int k = 0; k < SM; k++) begin
      if (k == 3) begin fire = 1'b1; scramble_req = 1'b1; end
      @(posedge clk);
      idx = (v >> 1) & (N - 1);
      if (idx >= N) idx -= N;
      model_move(v[0], idx, 1'b0);
      v = lfsr_model(v);
      if (k == SM - 1) begin m_busy = 0; m_armed = 1; chk_pending = 1; end
      @(negedge clk);
      fire = 1'b0; scramble_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fire = 0; sel_nrow = 0; sel_idx = 0; add_n = 0; scramble_req = 0; seed = 0;
    fire3 = 0; idx3 = 0; reset = 0; busy_cycles = 0;
    model_clear();
    chk_en = 0;
    @(negedge clk);
    hard_reset();

    chk("reset_cells", 64'(cell_state), 64'h0);
    chk("reset_count", 64'(move_count), 64'h0);
    chk("lfsr_model_pin", 64'(lfsr_model('hACE1)), 64'h59C3);

    // Row 1 increment
    move_fire(1'b0, 1, 1'b0);
    chk("row1_cells", 64'(cell_state), 64'h0000_5500);
    chk("row1_count", 64'(move_count), 64'd1);
    cyc();
    chk("row1_win", 64'(win), 64'd0);

    // Four column increments -> uniform grid of ones
    hard_reset();
    for (int i = 0; i < N; i++) begin
      move_fire(1'b1, i, 1'b0);
      cyc();
    end
    chk("cols_cells", 64'(cell_state), 64'h5555_5555);
    chk("cols_win", 64'(win), 64'd1);
    chk("cols_count", 64'(move_count), 64'd4);

    // Decrement wrap then increment back
    hard_reset();
    move_fire(1'b0, 2, 1'b1);
    chk("dec_wrap", 64'(cell_state), 64'h00FF_0000);
    cyc();
    move_fire(1'b0, 2, 1'b0);
    chk("inc_back", 64'(cell_state), 64'h0);
    cyc();
    chk("zero_win", 64'(win), 64'd1);

    // GRID_N=3 out-of-range index
    idx3 = 2'd2; sel_nrow = 1'b0; add_n = 1'b0; fire3 = 1'b1;
    @(negedge clk); fire3 = 1'b0;
    cyc();
    chk("g3_cells", 64'(cell3), 64'h15000);
    chk("g3_count", 64'(count3), 64'd1);
    idx3 = 2'd3; fire3 = 1'b1;
    @(negedge clk); fire3 = 1'b0;
    chk("g3_sel_err", 64'(sel_err3), 64'd1);
    chk("g3_cells_kept", 64'(cell3), 64'h15000);
    chk("g3_count_kept", 64'(count3), 64'd1);
    @(negedge clk);
    chk("g3_sel_err_clr", 64'(sel_err3), 64'd0);
    chk("g3_busy_win", 64'({busy3, win3}), 64'd0);

`ifdef PUZZLE_GRID_SCRAMBLE_EN
    hard_reset();
    busy_cycles = 0;
    scramble(16'h0001, 1'b1);
    cyc();
    chk("scr_busy_cycles", 64'(busy_cycles), 64'd16);
    chk("scr_cells", 64'(cell_state), 64'h6B6B_BC16);
    chk("scr_count", 64'(move_count), 64'd0);
    chk("scr_win", 64'(win), 64'd0);
    move_fire(1'b0, 0, 1'b0);
    cyc();
    chk("post_scr_count", 64'(move_count), 64'd1);

    // Reset during scramble
    scramble_req = 1'b1; seed = 16'h1234;
    @(negedge clk);
    scramble_req = 1'b0;
    chk_en = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_scr_busy", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_cells", 64'(cell_state), 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(move_count), 64'd0);
    chk("rst_win_err", 64'({win, sel_err}), 64'd0);
    @(negedge clk);
    hard_reset();
`else
    hard_reset();
    move_fire(1'b0, 0, 1'b0);
    cyc();
    scramble_req = 1'b1; seed = 16'h0001;
    cyc();
    scramble_req = 1'b0;
    repeat (4) cyc();
    chk("noscr_busy", 64'(busy), 64'd0);
    chk("noscr_cells", 64'(cell_state), 64'h0000_0055);
    chk_en = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_cells", 64'(cell_state), 64'h0);
    chk("rst_count", 64'(move_count), 64'd0);
    chk("rst_win_err", 64'({win, sel_err, busy}), 64'd0);
    @(negedge clk);
    hard_reset();
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
